// File: rtl/ysyx_041514_pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stage bit positions, FSM states,
// redirect kinds and the fixed redirect flush masks.
package ysyx_041514_pipe_ctrl_pkg;

   localparam int PIPE_XLEN   = 64;
   localparam int PIPE_NSTAGE = 6;

   localparam int CTRLBUS_PC  = 0;
   localparam int CTRLBUS_IF  = 1;
   localparam int CTRLBUS_ID  = 2;
   localparam int CTRLBUS_EXE = 3;
   localparam int CTRLBUS_MEM = 4;
   localparam int CTRLBUS_WB  = 5;

   // trap/fence.i squash IF..MEM, a branch resolved in EXE squashes IF..ID
   localparam logic [PIPE_NSTAGE-1:0] FLUSH_LONG  = 6'b011110;
   localparam logic [PIPE_NSTAGE-1:0] FLUSH_SHORT = 6'b000110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FENCE = 2'd2
   } ctrl_state_e;

   typedef enum logic [1:0] {
      RK_NONE   = 2'd0,
      RK_BRANCH = 2'd1,
      RK_TRAP   = 2'd2,
      RK_FENCE  = 2'd3
   } redir_kind_e;

   typedef struct packed {
      redir_kind_e           kind;
      logic [PIPE_XLEN-1:0]  pc;
   } redir_t;

endpackage

// File: rtl/ysyx_041514_pipe_ctrl_if.sv
// Handshake/bus bundle between the pipeline stages, the icache and the controller.
interface ysyx_041514_pipe_ctrl_if
   import ysyx_041514_pipe_ctrl_pkg::*;
#(
   parameter int XLEN   = PIPE_XLEN,
   parameter int NSTAGE = PIPE_NSTAGE
);
   logic              if_stall_req_i;
   logic              id_stall_req_i;
   logic              exe_stall_req_i;
   logic              mem_stall_req_i;
   logic              branch_valid_i;
   logic [XLEN-1:0]   branch_pc_i;
   logic              trap_valid_i;
   logic [XLEN-1:0]   trap_pc_i;
   logic              fencei_valid_i;
   logic [XLEN-1:0]   fencei_pc_i;
   logic              icache_flush_done_i;
   logic              icache_flush_o;
   logic [NSTAGE-1:0] stall_valid_o;
   logic [NSTAGE-1:0] flush_valid_o;
   logic [XLEN-1:0]   branch_pc_o;
   logic              branch_pc_valid_o;
   logic [XLEN-1:0]   clint_pc_o;
   logic              clint_pc_valid_o;
   logic              clint_pc_plus4_valid_o;

   modport master (
      output if_stall_req_i, id_stall_req_i, exe_stall_req_i, mem_stall_req_i,
             branch_valid_i, branch_pc_i, trap_valid_i, trap_pc_i,
             fencei_valid_i, fencei_pc_i, icache_flush_done_i,
      input  icache_flush_o, stall_valid_o, flush_valid_o, branch_pc_o,
             branch_pc_valid_o, clint_pc_o, clint_pc_valid_o, clint_pc_plus4_valid_o
   );

   modport slave (
      input  if_stall_req_i, id_stall_req_i, exe_stall_req_i, mem_stall_req_i,
             branch_valid_i, branch_pc_i, trap_valid_i, trap_pc_i,
             fencei_valid_i, fencei_pc_i, icache_flush_done_i,
      output icache_flush_o, stall_valid_o, flush_valid_o, branch_pc_o,
             branch_pc_valid_o, clint_pc_o, clint_pc_valid_o, clint_pc_plus4_valid_o
   );
endinterface

// File: rtl/ysyx_041514_stall_gen.sv
// Priority stall/bubble encoder: the oldest requesting stage stalls itself and
// everything younger, and a bubble is inserted into the stage after it.
module ysyx_041514_stall_gen
   import ysyx_041514_pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE = PIPE_NSTAGE
) (
   input  logic              if_req_i,
   input  logic              id_req_i,
   input  logic              exe_req_i,
   input  logic              mem_req_i,
   output logic [NSTAGE-1:0] stall_o,
   output logic [NSTAGE-1:0] flush_o
);

   always_comb begin
      stall_o = '0;
      flush_o = '0;
      if (mem_req_i) begin
         // WB holds its result rather than taking a bubble
         stall_o[CTRLBUS_WB:CTRLBUS_PC] = '1;
      end else if (exe_req_i) begin
         stall_o[CTRLBUS_EXE:CTRLBUS_PC] = '1;
         flush_o[CTRLBUS_MEM]            = 1'b1;
      end else if (id_req_i) begin
         stall_o[CTRLBUS_ID:CTRLBUS_PC]  = '1;
         flush_o[CTRLBUS_EXE]            = 1'b1;
      end else if (if_req_i) begin
         stall_o[CTRLBUS_IF:CTRLBUS_PC]  = '1;
         flush_o[CTRLBUS_ID]             = 1'b1;
      end
   end

endmodule

// File: rtl/ysyx_041514_pipe_ctrl.sv
// Pipeline controller: stall/flush buses, redirect arbitration, pending redirect
// while the PC is stalled, and fence.i icache sequencing. YSYX_041514_PIPE_PERF_EN adds perf counters.
module ysyx_041514_pipe_ctrl
   import ysyx_041514_pipe_ctrl_pkg::*;
#(
   parameter int XLEN   = PIPE_XLEN,
   parameter int NSTAGE = PIPE_NSTAGE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ysyx_041514_pipe_ctrl_if.slave bus
`ifdef YSYX_041514_PIPE_PERF_EN
   ,
   output logic [63:0]           perf_stall_cycles_o,
   output logic [63:0]           perf_redirect_cnt_o
`endif
);

   ctrl_state_e       state_q;
   redir_t            pend_q;
   logic              icache_flush_q;

   logic [NSTAGE-1:0] sg_stall, sg_flush;
   logic [NSTAGE-1:0] rflush, ctl_stall;
   logic              iss_br, iss_cl, iss_p4;
   logic [XLEN-1:0]   iss_pc;
   redir_t            eff;

   ysyx_041514_stall_gen #(.NSTAGE(NSTAGE)) u_stall_gen (
      .if_req_i  (bus.if_stall_req_i),
      .id_req_i  (bus.id_stall_req_i),
      .exe_req_i (bus.exe_stall_req_i),
      .mem_req_i (bus.mem_stall_req_i),
      .stall_o   (sg_stall),
      .flush_o   (sg_flush)
   );

   always_comb begin
      iss_br    = 1'b0;
      iss_cl    = 1'b0;
      iss_p4    = 1'b0;
      iss_pc    = '0;
      rflush    = '0;
      ctl_stall = '0;
      // a trap arriving this cycle always beats whatever is waiting
      eff.kind  = bus.trap_valid_i ? RK_TRAP : pend_q.kind;
      eff.pc    = bus.trap_valid_i ? bus.trap_pc_i : pend_q.pc;
      case (state_q)
         ST_IDLE: begin
            if (bus.trap_valid_i) begin
               rflush = FLUSH_LONG;
               if (!bus.if_stall_req_i) begin
                  iss_cl = 1'b1;
                  iss_pc = bus.trap_pc_i;
               end
            end else if (bus.fencei_valid_i) begin
               rflush = FLUSH_LONG;
            end else if (bus.branch_valid_i) begin
               rflush = FLUSH_SHORT;
               if (!bus.if_stall_req_i) begin
                  iss_br = 1'b1;
                  iss_pc = bus.branch_pc_i;
               end
            end
         end
         ST_HOLD: begin
            if (bus.trap_valid_i) rflush = FLUSH_LONG;
            if (!bus.if_stall_req_i) begin
               iss_br = (eff.kind == RK_BRANCH);
               iss_cl = (eff.kind == RK_TRAP);
               iss_pc = eff.pc;
            end else begin
               ctl_stall[CTRLBUS_PC] = 1'b1;
            end
         end
         ST_FENCE: begin
            if (bus.trap_valid_i) rflush = FLUSH_LONG;
            if (bus.icache_flush_done_i) begin
               iss_cl = 1'b1;
               iss_p4 = (eff.kind == RK_FENCE);
               iss_pc = eff.pc;
            end else begin
               ctl_stall[CTRLBUS_IF:CTRLBUS_PC] = '1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         pend_q         <= '0;
         icache_flush_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.trap_valid_i) begin
                  if (bus.if_stall_req_i) begin
                     pend_q  <= '{kind: RK_TRAP, pc: bus.trap_pc_i};
                     state_q <= ST_HOLD;
                  end
               end else if (bus.fencei_valid_i) begin
                  pend_q         <= '{kind: RK_FENCE, pc: bus.fencei_pc_i};
                  icache_flush_q <= 1'b1;
                  state_q        <= ST_FENCE;
               end else if (bus.branch_valid_i && bus.if_stall_req_i) begin
                  pend_q  <= '{kind: RK_BRANCH, pc: bus.branch_pc_i};
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!bus.if_stall_req_i) begin
                  pend_q  <= '0;
                  state_q <= ST_IDLE;
               end else if (bus.trap_valid_i) begin
                  pend_q  <= '{kind: RK_TRAP, pc: bus.trap_pc_i};
               end
            end
            ST_FENCE: begin
               if (bus.icache_flush_done_i) begin
                  pend_q         <= '0;
                  icache_flush_q <= 1'b0;
                  state_q        <= ST_IDLE;
               end else if (bus.trap_valid_i) begin
                  pend_q <= '{kind: RK_TRAP, pc: bus.trap_pc_i};
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // flushed stages drop their stall; combinational outputs are forced quiet during reset
   logic [NSTAGE-1:0] stall_all, flush_all;
   assign stall_all = (sg_stall | ctl_stall) & ~rflush;
   assign flush_all = (sg_flush | rflush) & ~{{(NSTAGE-1){1'b0}}, 1'b1};

   assign bus.stall_valid_o          = rst_n ? stall_all : '0;
   assign bus.flush_valid_o          = rst_n ? flush_all : '0;
   assign bus.branch_pc_valid_o      = rst_n & iss_br;
   assign bus.branch_pc_o            = (rst_n & iss_br) ? iss_pc : '0;
   assign bus.clint_pc_valid_o       = rst_n & iss_cl;
   assign bus.clint_pc_plus4_valid_o = rst_n & iss_cl & iss_p4;
   assign bus.clint_pc_o             = (rst_n & iss_cl) ? iss_pc : '0;
   assign bus.icache_flush_o         = icache_flush_q;

`ifdef YSYX_041514_PIPE_PERF_EN
   logic [63:0] perf_stall_q, perf_redir_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_redir_q <= '0;
      end else begin
         if (bus.stall_valid_o[CTRLBUS_PC])                perf_stall_q <= perf_stall_q + 64'd1;
         if (bus.branch_pc_valid_o | bus.clint_pc_valid_o) perf_redir_q <= perf_redir_q + 64'd1;
      end
   end
   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_redirect_cnt_o = perf_redir_q;
`endif

endmodule

// File: tb/tb_ysyx_041514_pipe_ctrl.sv
// Scoreboard bench for ysyx_041514_pipe_ctrl: stimulus pushes expected bus state
// and redirect pulses; a negedge monitor pops and compares.
module tb_ysyx_041514_pipe_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_041514_pipe_ctrl_if bus ();

`ifdef YSYX_041514_PIPE_PERF_EN
   logic [63:0] perf_stall, perf_redir;
   ysyx_041514_pipe_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                              .perf_stall_cycles_o(perf_stall), .perf_redirect_cnt_o(perf_redir));
`else
   ysyx_041514_pipe_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   typedef struct { int cyc; string nm; logic [5:0] st; logic [5:0] fl; logic icf; } bexp_t;
   typedef struct { int cyc; string nm; logic [1:0] kind; logic [63:0] pc; logic p4; } rexp_t;
   bexp_t bq[$];
   rexp_t rq[$];

   localparam logic [1:0] K_BR = 2'b10;
   localparam logic [1:0] K_CL = 2'b01;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc%0d: got %h want %h", nm, cyc, act, exp);
   endtask

   // one cycle of stimulus; stall vector order {mem,exe,id,if}
   task automatic drv(input logic [3:0] st, input logic br, input logic [63:0] bpc,
                      input logic tr, input logic [63:0] tpc,
                      input logic fi, input logic [63:0] fpc, input logic dn);
      @(posedge clk); #1;
      {bus.mem_stall_req_i, bus.exe_stall_req_i, bus.id_stall_req_i, bus.if_stall_req_i} = st;
      bus.branch_valid_i = br;  bus.branch_pc_i = bpc;
      bus.trap_valid_i   = tr;  bus.trap_pc_i   = tpc;
      bus.fencei_valid_i = fi;  bus.fencei_pc_i = fpc;
      bus.icache_flush_done_i = dn;
   endtask

   task automatic idle();
      drv(4'b0000, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic eb(input string nm, input logic [5:0] st, input logic [5:0] fl, input logic icf);
      bq.push_back('{cyc, nm, st, fl, icf});
   endtask

   task automatic er(input string nm, input logic [1:0] k, input logic [63:0] pc, input logic p4);
      rq.push_back('{cyc, nm, k, pc, p4});
   endtask

   always @(negedge clk) begin
      while (bq.size() > 0 && bq[0].cyc == cyc) begin
         bexp_t b;
         b = bq.pop_front();
         chk({b.nm, "_bus"}, {bus.stall_valid_o, bus.flush_valid_o, bus.icache_flush_o},
             {b.st, b.fl, b.icf});
      end
      if (bus.branch_pc_valid_o || bus.clint_pc_valid_o) begin
         if (rq.size() == 0) begin
            chk("unexpected_redirect", {bus.branch_pc_valid_o, bus.clint_pc_valid_o}, 2'b00);
         end else begin
            rexp_t r;
            logic [63:0] apc;
            r = rq.pop_front();
            apc = bus.branch_pc_valid_o ? bus.branch_pc_o : bus.clint_pc_o;
            chk({r.nm, "_redir"},
                {32'(cyc), bus.branch_pc_valid_o, bus.clint_pc_valid_o, apc, bus.clint_pc_plus4_valid_o},
                {32'(r.cyc), r.kind, r.pc, r.p4});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.if_stall_req_i = 0; bus.id_stall_req_i = 0; bus.exe_stall_req_i = 0; bus.mem_stall_req_i = 0;
      bus.branch_valid_i = 0; bus.branch_pc_i = 0; bus.trap_valid_i = 0; bus.trap_pc_i = 0;
      bus.fencei_valid_i = 0; bus.fencei_pc_i = 0; bus.icache_flush_done_i = 0;

      // reset: outputs quiet even with a stall request present
      drv(4'b1000, 0, 0, 0, 0, 0, 0, 0);            eb("rst",   6'b000000, 6'b000000, 0);
      idle(); rst_n = 1'b1;                         eb("rel",   6'b000000, 6'b000000, 0);

      drv(4'b1010, 0, 0, 0, 0, 0, 0, 0);            eb("memid", 6'b111111, 6'b000000, 0);
      drv(4'b0010, 0, 0, 0, 0, 0, 0, 0);            eb("id",    6'b000111, 6'b001000, 0);
      drv(4'b0100, 0, 0, 0, 0, 0, 0, 0);            eb("exe",   6'b001111, 6'b010000, 0);
      drv(4'b0001, 0, 0, 0, 0, 0, 0, 0);            eb("if",    6'b000011, 6'b000100, 0);
      idle();                                       eb("quiet", 6'b000000, 6'b000000, 0);

      drv(4'b0000, 1, 64'h8000_0100, 0, 0, 0, 0, 0); eb("br",   6'b000000, 6'b000110, 0);
                                                     er("br",   K_BR, 64'h8000_0100, 0);
      drv(4'b0000, 1, 64'h8000_0999, 1, 64'h8000_1000, 0, 0, 0);
                                                     eb("trbr", 6'b000000, 6'b011110, 0);
                                                     er("trbr", K_CL, 64'h8000_1000, 0);

      // branch held behind IF stall, overwritten by a trap
      drv(4'b0001, 1, 64'h8000_0300, 0, 0, 0, 0, 0); eb("hb0",  6'b000001, 6'b000110, 0);
      drv(4'b0001, 0, 0, 1, 64'h8000_0004, 0, 0, 0); eb("hb1",  6'b000001, 6'b011110, 0);
      drv(4'b0001, 0, 0, 0, 0, 0, 0, 0);             eb("hb2",  6'b000011, 6'b000100, 0);
      idle();                                        eb("hb3",  6'b000000, 6'b000000, 0);
                                                     er("hb3",  K_CL, 64'h8000_0004, 0);
      idle();                                        eb("hb4",  6'b000000, 6'b000000, 0);

      // fence.i with done on the fifth cycle of icache_flush_o
      drv(4'b0000, 0, 0, 0, 0, 1, 64'h8000_0200, 0); eb("fi0",  6'b000000, 6'b011110, 0);
      for (int i = 1; i <= 4; i++) begin
         idle();                                     eb("fiw",  6'b000011, 6'b000000, 1);
      end
      drv(4'b0000, 0, 0, 0, 0, 0, 0, 1);             eb("fi5",  6'b000000, 6'b000000, 1);
                                                     er("fi5",  K_CL, 64'h8000_0200, 1);
      idle();                                        eb("fi6",  6'b000000, 6'b000000, 0);

      // trap aborts a fence.i
      drv(4'b0000, 0, 0, 0, 0, 1, 64'h8000_0400, 0); eb("fa0",  6'b000000, 6'b011110, 0);
      drv(4'b0000, 0, 0, 1, 64'h8000_0008, 0, 0, 0); eb("fa1",  6'b000001, 6'b011110, 1);
      idle();                                        eb("fa2",  6'b000011, 6'b000000, 1);
      drv(4'b0000, 0, 0, 0, 0, 0, 0, 1);             eb("fa3",  6'b000000, 6'b000000, 1);
                                                     er("fa3",  K_CL, 64'h8000_0008, 0);
      idle();                                        eb("fa4",  6'b000000, 6'b000000, 0);

      // second branch while holding is dropped
      drv(4'b0001, 1, 64'h8000_0500, 0, 0, 0, 0, 0); eb("hd0",  6'b000001, 6'b000110, 0);
      drv(4'b0001, 1, 64'h8000_0600, 0, 0, 0, 0, 0); eb("hd1",  6'b000011, 6'b000100, 0);
      idle();                                        eb("hd2",  6'b000000, 6'b000000, 0);
                                                     er("hd2",  K_BR, 64'h8000_0500, 0);

      // branch during MEM stall: flushed stages drop their stall
      drv(4'b1000, 1, 64'h8000_0700, 0, 0, 0, 0, 0); eb("mb",   6'b111001, 6'b000110, 0);
                                                     er("mb",   K_BR, 64'h8000_0700, 0);

      // asynchronous reset while in FENCE
      drv(4'b0000, 0, 0, 0, 0, 1, 64'h8000_0800, 0); eb("rf0",  6'b000000, 6'b011110, 0);
      idle();                                        eb("rf1",  6'b000011, 6'b000000, 1);
      idle(); rst_n = 1'b0;                          eb("rf2",  6'b000000, 6'b000000, 0);
      idle();                                        eb("rf3",  6'b000000, 6'b000000, 0);
      idle(); rst_n = 1'b1;                          eb("rf4",  6'b000000, 6'b000000, 0);
      drv(4'b0000, 0, 0, 0, 0, 0, 0, 1);             eb("rf5",  6'b000000, 6'b000000, 0);
      drv(4'b0000, 1, 64'h8000_0900, 0, 0, 0, 0, 0); eb("rf6",  6'b000000, 6'b000110, 0);
                                                     er("rf6",  K_BR, 64'h8000_0900, 0);
      idle();                                        eb("end",  6'b000000, 6'b000000, 0);

      @(posedge clk); @(posedge clk); #1;
      chk("bq_drained", 32'(bq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_041514_pipe_ctrl.md
Name: ysyx_041514_pipe_ctrl

Overview:
- Central pipeline controller. Generates the 6-bit stall and flush buses consumed by the PC register and the IF/ID/EXE/MEM/WB pipeline registers.
- Arbitrates PC redirects: trap from MEM, fence.i from MEM, branch from EXE.
- Holds a redirect pending while the PC stage is stalled, so no redirect is lost.
- Sequences fence.i through an icache-invalidate handshake before refetching at pc+4.

Parameters:
- XLEN, 64, width of PC and redirect targets.
- NSTAGE, 6, width of stall/flush buses; bit order PC=0, IF=1, ID=2, EXE=3, MEM=4, WB=5.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_stall_req_i  in  1  icache miss/busy.
- id_stall_req_i  in  1  load-use hazard.
- exe_stall_req_i  in  1  multi-cycle mul/div busy.
- mem_stall_req_i  in  1  dcache/bus busy.
- branch_valid_i  in  1  EXE mispredict redirect.
- branch_pc_i  in  XLEN  branch target.
- trap_valid_i  in  1  MEM trap/mret redirect.
- trap_pc_i  in  XLEN  trap/mret target.
- fencei_valid_i  in  1  fence.i retiring in MEM.
- fencei_pc_i  in  XLEN  PC of the fence.i.
- icache_flush_done_i  in  1  icache invalidate complete (single-cycle pulse).
- icache_flush_o  out  1  icache invalidate request (level).
- stall_valid_o  out  NSTAGE  per-stage stall.
- flush_valid_o  out  NSTAGE  per-stage bubble insert.
- branch_pc_o  out  XLEN  to PC reg.
- branch_pc_valid_o  out  1  to PC reg.
- clint_pc_o  out  XLEN  to PC reg.
- clint_pc_valid_o  out  1  to PC reg.
- clint_pc_plus4_valid_o  out  1  to PC reg; fence.i refetch at clint_pc_o+4.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; pending register cleared. Reset is asynchronous, release is synchronous to clk, and reset asserted mid-operation aborts any state immediately.
- Stall bus (combinational):
  - Take the oldest requesting stage k (MEM > EXE > ID > IF).
  - stall_valid_o[0..k] = 1.
  - flush_valid_o[k+1] = 1 (bubble), except when k = MEM: WB is not flushed and stalls with it, so stall_valid_o[5] = 1.
- Redirect priority: trap > fence.i > branch. A lower-priority request in the same cycle is dropped.
- Redirect flush (combinational, same cycle as the request):
  - trap or fence.i: flush_valid_o[1..4] = 1.
  - branch: flush_valid_o[1..2] = 1.
  - Redirect flush ORs with stall bubbles.
  - flush_valid_o[0] is never asserted.
- FSM states:
  - IDLE:
    - trap or branch with if_stall_req_i = 0: drive the matching *_valid_o and pc for 1 cycle (0-cycle latency); stay IDLE.
    - trap or branch with if_stall_req_i = 1: latch {kind, pc} into the pending register → HOLD.
    - fence.i: latch pc; icache_flush_o = 1 → FENCE.
  - HOLD:
    - Outputs quiet, stall_valid_o[0] = 1.
    - A new trap overwrites a pending branch. A new branch is dropped, since the older-path branch is flushed.
    - When if_stall_req_i = 0: issue the pending redirect for 1 cycle → IDLE.
  - FENCE:
    - icache_flush_o held at 1; stall_valid_o[0..1] = 1.
    - A trap aborts: icache_flush_o stays 1 until done, and the trap pc is latched.
    - On icache_flush_done_i: issue clint_pc_valid_o = 1 and clint_pc_plus4_valid_o = 1 with clint_pc_o = fence pc → IDLE. If a trap was latched, issue the trap instead (plus4 = 0).
- Only one of branch_pc_valid_o / clint_pc_valid_o is high in any cycle. Each is a single-cycle pulse per redirect.
- Redirect and stall in the same cycle: the redirect flush takes precedence for stages ≤ the flushed range. Stalls of older stages remain.
- Widths: pc registers XLEN wide. No arithmetic here; the +4 is performed in the PC reg.

Optional Feature:
- Macro: YSYX_041514_PIPE_PERF_EN.
- When defined, add 64-bit counters `perf_stall_cycles_o` (any stall_valid_o[0]) and `perf_redirect_cnt_o` (each issued redirect pulse). Both reset to 0, increment by 1, and wrap at 2^64.
- When undefined, the ports and counters are absent.

Decomposition:
- Stage index constants (CTRLBUS_PC..WB), the FSM state encoding, and redirect-kind codes go in the shared config header/package.
- One sub-module, ysyx_041514_stall_gen: purely the priority stall/bubble encoder. The FSM and pending register stay in the top.

Test Plan:
- mem_stall_req_i = 1, id_stall_req_i = 1 → stall_valid_o = 6'b111111, flush_valid_o = 0.
- id_stall_req_i = 1 only → stall_valid_o = 6'b000111, flush_valid_o = 6'b001000.
- branch_valid_i = 1, pc 0x8000_0100, no IF stall → same cycle branch_pc_valid_o = 1, branch_pc_o = 0x8000_0100, flush_valid_o = 6'b000110.
- branch with if_stall_req_i = 1 for 3 cycles, trap to 0x8000_0004 arriving in cycle 2 → no pulse while stalled; then a single clint_pc_valid_o pulse with 0x8000_0004, and no branch pulse.
- fence.i at pc 0x8000_0200, icache_flush_done_i after 5 cycles → icache_flush_o high 5 cycles, then clint_pc_valid_o = 1, clint_pc_plus4_valid_o = 1, clint_pc_o = 0x8000_0200.
- rst_n low while in FENCE → all outputs 0 asynchronously; after release, FSM in IDLE and icache_flush_o = 0.
